drp_reg_target: RTL



---
 rtl/drp_reg_target_if.sv | 25 ++
 rtl/drp_reg_target.sv | 117 +++++++++++
 2 files changed

// File: rtl/drp_reg_target_if.sv
// DRP bus bundle between a DRP master and a register target.
// The master drives the request strobe; the target returns data, ready and status.
interface drp_reg_target_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] drpaddr;
    logic [DATA_WIDTH-1:0] drpdi;
    logic                  drpen;
    logic                  drpwe;
    logic [DATA_WIDTH-1:0] drpdo;
    logic                  drprdy;
    logic                  busy;
    logic [7:0]            err_cnt;

    modport master (
        output drpaddr, drpdi, drpen, drpwe,
        input  drpdo, drprdy, busy, err_cnt
    );

    modport slave (
        input  drpaddr, drpdi, drpen, drpwe,
        output drpdo, drprdy, busy, err_cnt
    );
endinterface

// File: rtl/drp_reg_target.sv
// DRP responder: fixed-latency single-outstanding access to a small register bank.
// Address 0 is a read-only ID; EN pulses that arrive while busy are counted.
module drp_reg_target #(
    parameter int                  ADDR_WIDTH = 9,
    parameter int                  DATA_WIDTH = 16,
    parameter int                  NUM_REGS   = 16,
    parameter int                  LATENCY    = 3,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE  = 16'hD5A0,
    parameter logic [DATA_WIDTH-1:0] OOR_VALUE = 16'hBAD0
) (
    input  logic               s_drpclk,
    input  logic               s_drprstn,
    drp_reg_target_if.slave    drp
);
    localparam int         IW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                state, state_n;
    logic [3:0]            cnt, cnt_n;
    logic                  accept;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] di_q;
    logic                  we_q;

    logic [ADDR_WIDTH-1:0] eff_addr;
    logic [DATA_WIDTH-1:0] eff_di;
    logic                  eff_we;
    logic                  in_range;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] rdata;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] do_q;
    logic                  rdy_q;
    logic                  busy_q;
    logic [7:0]            err_q;

    always_ff @(posedge s_drpclk) begin
        if (!s_drprstn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (drp.drpen) begin
                    accept  = 1'b1;
                    cnt_n   = LAT_M1;
                    state_n = (LATENCY == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    // With LATENCY=1 the DONE entry coincides with acceptance, so bypass the latches.
    always_comb begin
        eff_addr = accept ? drp.drpaddr : addr_q;
        eff_di   = accept ? drp.drpdi   : di_q;
        eff_we   = accept ? drp.drpwe   : we_q;
        in_range = {1'b0, eff_addr} < (ADDR_WIDTH + 1)'(NUM_REGS);
        idx      = eff_addr[IW-1:0];
        if (eff_addr == '0)
            rdata = ID_VALUE;
        else if (in_range)
            rdata = regs[idx];
        else
            rdata = OOR_VALUE;
    end

    always_ff @(posedge s_drpclk) begin
        if (!s_drprstn) begin
            addr_q <= '0;
            di_q   <= '0;
            we_q   <= 1'b0;
            do_q   <= '0;
            rdy_q  <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (accept) begin
                addr_q <= drp.drpaddr;
                di_q   <= drp.drpdi;
                we_q   <= drp.drpwe;
            end
            if (state_n == DONE && eff_we && in_range && eff_addr != '0)
                regs[idx] <= eff_di;
            do_q   <= (state_n == DONE && !eff_we) ? rdata : '0;
            rdy_q  <= (state_n == DONE);
            busy_q <= (state_n == WAIT);
            if (drp.drpen && state == WAIT && err_q != 8'hFF)
                err_q <= err_q + 8'd1;
        end
    end

    assign drp.drpdo   = do_q;
    assign drp.drprdy  = rdy_q;
    assign drp.busy    = busy_q;
    assign drp.err_cnt = err_q;
endmodule
